wb_grf: RTL and testbench

WB_GRF -- requirements
Module: wb_grf

---
 rtl/wb_grf.sv | 97 +++++++++
 tb/tb_wb_grf.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/wb_grf.sv
// ============================================================================
//  Module      : wb_grf
//  Description : Write-back stage general register file. Selects the
//                write-back data, commits it into a 32x32 register array,
//                bypasses it to the two D-stage read ports in the same cycle,
//                and counts committed register writes.
//  Options     : define WB_TRACE_EN to print one line per committed write
//                (simulation only).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_grf (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCW,
    input  logic        RegWriteW,
    input  logic [1:0]  RegSrcW,
    input  logic [31:0] ReadDataW,
    input  logic [31:0] ResultW,
    input  logic [4:0]  RegDstW,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    output logic [31:0] WDW,
    output logic        WECommitW,
    output logic [31:0] WBCount
);

    localparam logic [1:0]  SRC_ALU   = 2'b00;
    localparam logic [1:0]  SRC_MEM   = 2'b01;
    localparam logic [1:0]  SRC_LINK  = 2'b10;
    localparam logic [31:0] LINK_OFFS = 32'd8;

    logic [31:0] regs [32];
    logic [31:0] wb_count;

    // Write-back data select; the reserved encoding yields zero.
    always_comb begin
        WDW = 32'd0;
        case (RegSrcW)
            SRC_ALU:  WDW = ResultW;
            SRC_MEM:  WDW = ReadDataW;
            SRC_LINK: WDW = PCW + LINK_OFFS;
            default:  WDW = 32'd0;
        endcase
    end

    // A write commits only to a non-zero register with a valid data source.
    assign WECommitW = RegWriteW && (RegDstW != 5'd0) && (RegSrcW != 2'b11);

    // Register array and commit counter; reset wins over any pending commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
            wb_count <= 32'd0;
        end else if (WECommitW) begin
            regs[RegDstW] <= WDW;
            wb_count      <= wb_count + 32'd1;
        end
    end

    // Read ports: r0 is hard zero, then same-cycle bypass, then the array.
    // A committing write never targets r0, so the bypass cannot leak into it.
    always_comb begin
        RD1 = regs[A1];
        RD2 = regs[A2];
        if (A1 == 5'd0) begin
            RD1 = 32'd0;
        end else if (WECommitW && (A1 == RegDstW)) begin
            RD1 = WDW;
        end
        if (A2 == 5'd0) begin
            RD2 = 32'd0;
        end else if (WECommitW && (A2 == RegDstW)) begin
            RD2 = WDW;
        end
    end

    assign WBCount = wb_count;

`ifdef WB_TRACE_EN
    // Trace each committed register write, matching the commit condition.
    always_ff @(posedge clk) begin
        if (!reset && WECommitW) begin
            $display("@%h: $%d <= %h", PCW, RegDstW, WDW);
        end
    end
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_grf.sv
// ============================================================================
//  Module      : tb_wb_grf
//  Description : Directed self-checking bench for wb_grf.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_grf;

    logic        clk;
    logic        reset;
    logic [31:0] PCW;
    logic        RegWriteW;
    logic [1:0]  RegSrcW;
    logic [31:0] ReadDataW;
    logic [31:0] ResultW;
    logic [4:0]  RegDstW;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] WDW;
    logic        WECommitW;
    logic [31:0] WBCount;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    wb_grf dut (
        .clk       (clk),
        .reset     (reset),
        .PCW       (PCW),
        .RegWriteW (RegWriteW),
        .RegSrcW   (RegSrcW),
        .ReadDataW (ReadDataW),
        .ResultW   (ResultW),
        .RegDstW   (RegDstW),
        .A1        (A1),
        .A2        (A2),
        .RD1       (RD1),
        .RD2       (RD2),
        .WDW       (WDW),
        .WECommitW (WECommitW),
        .WBCount   (WBCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, reports a failure with observed/expected.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, then let combinational logic settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        PCW       = 32'd0;
        RegWriteW = 1'b0;
        RegSrcW   = 2'b00;
        ReadDataW = 32'd0;
        ResultW   = 32'd0;
        RegDstW   = 5'd0;
        A1        = 5'd5;
        A2        = 5'd31;
        tick();
        tick();
        check("reset_rd1",     RD1, 32'd0);
        check("reset_rd2",     RD2, 32'd0);
        check("reset_count",   WBCount, 32'd0);
        check("reset_commit",  {31'd0, WECommitW}, 32'd0);

        // ALU result into r5, bypass then array.
        reset = 1'b0; RegWriteW = 1'b1; RegSrcW = 2'b00; ResultW = 32'h1234; RegDstW = 5'd5;
        A1 = 5'd5; A2 = 5'd0;
        #1;
        check("alu_wdw",       WDW, 32'h1234);
        check("alu_commit",    {31'd0, WECommitW}, 32'd1);
        check("alu_bypass",    RD1, 32'h1234);
        check("alu_rd2_r0",    RD2, 32'd0);
        tick();
        RegWriteW = 1'b0; ResultW = 32'hAAAA_5555;
        #1;
        check("alu_array",     RD1, 32'h1234);
        check("alu_count",     WBCount, 32'd1);
        check("nocommit_wdw",  WDW, 32'hAAAA_5555);
        check("nocommit_nobyp",RD1, 32'h1234);

        // Link write PCW+8 into r31 with bypass on port 2.
        RegWriteW = 1'b1; RegSrcW = 2'b10; PCW = 32'h0000_3000; RegDstW = 5'd31; A2 = 5'd31;
        #1;
        check("link_bypass",   RD2, 32'h0000_3008);
        tick();
        RegWriteW = 1'b0;
        #1;
        check("link_array",    RD2, 32'h0000_3008);
        check("link_count",    WBCount, 32'd2);

        // Link wraps modulo 2^32.
        RegWriteW = 1'b1; PCW = 32'hFFFF_FFFC; RegDstW = 5'd7; A1 = 5'd7;
        #1;
        check("link_wrap",     WDW, 32'h0000_0004);
        tick();
        RegWriteW = 1'b0;

        // Write to r0 is discarded and does not commit.
        RegWriteW = 1'b1; RegSrcW = 2'b00; ResultW = 32'hFFFF_FFFF; RegDstW = 5'd0; A1 = 5'd0;
        #1;
        check("r0_commit",     {31'd0, WECommitW}, 32'd0);
        check("r0_bypass",     RD1, 32'd0);
        tick();
        RegWriteW = 1'b0;
        #1;
        check("r0_array",      RD1, 32'd0);
        check("r0_count",      WBCount, 32'd3);

        // Memory data into r8 with both ports reading r8.
        RegWriteW = 1'b1; RegSrcW = 2'b01; ReadDataW = 32'hDEAD_BEEF; RegDstW = 5'd8;
        A1 = 5'd8; A2 = 5'd8;
        #1;
        check("mem_rd1",       RD1, 32'hDEAD_BEEF);
        check("mem_rd2",       RD2, 32'hDEAD_BEEF);
        tick();
        RegWriteW = 1'b0;
        #1;
        check("mem_array",     RD2, 32'hDEAD_BEEF);
        check("mem_count",     WBCount, 32'd4);

        // Reserved source: no commit, zero data, r9 untouched.
        RegWriteW = 1'b1; RegSrcW = 2'b11; ResultW = 32'h5555_0000; RegDstW = 5'd9; A1 = 5'd9;
        #1;
        check("rsv_wdw",       WDW, 32'd0);
        check("rsv_commit",    {31'd0, WECommitW}, 32'd0);
        tick();
        RegWriteW = 1'b0;
        #1;
        check("rsv_array",     RD1, 32'd0);
        check("rsv_count",     WBCount, 32'd4);

        // Fill r1..r3, then reset with a commit pending.
        RegWriteW = 1'b1; RegSrcW = 2'b00;
        RegDstW = 5'd1; ResultW = 32'h11; tick();
        RegDstW = 5'd2; ResultW = 32'h22; tick();
        RegDstW = 5'd3; ResultW = 32'h33; tick();
        RegWriteW = 1'b0; A1 = 5'd2; A2 = 5'd3;
        #1;
        check("fill_r2",       RD1, 32'h22);
        check("fill_r3",       RD2, 32'h33);
        check("fill_count",    WBCount, 32'd7);
        reset = 1'b1; RegWriteW = 1'b1; RegDstW = 5'd4; ResultW = 32'h44;
        tick();
        RegWriteW = 1'b0; reset = 1'b0; A1 = 5'd1; A2 = 5'd4;
        #1;
        check("rst_r1",        RD1, 32'd0);
        check("rst_r4",        RD2, 32'd0);
        check("rst_count",     WBCount, 32'd0);
        A1 = 5'd8; A2 = 5'd31;
        #1;
        check("rst_r8",        RD1, 32'd0);
        check("rst_r31",       RD2, 32'd0);

        // Counter wrap from all-ones.
        force dut.wb_count = 32'hFFFF_FFFF;
        #1;
        release dut.wb_count;
        #1;
        check("wrap_pre",      WBCount, 32'hFFFF_FFFF);
        RegWriteW = 1'b1; RegSrcW = 2'b00; RegDstW = 5'd12; ResultW = 32'hCAFE; A1 = 5'd12;
        tick();
        RegWriteW = 1'b0;
        #1;
        check("wrap_count",    WBCount, 32'd0);
        check("wrap_data",     RD1, 32'hCAFE);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

`default_nettype wire
